branch_unit: RTL

Branch-slot execute unit for the 4-wide VLIW core. It resolves the single branch operation per bundle and drives `branch_taken`/`new_pc` into the program counter. It suppresses wrong-path branches during the post-redirect shadow and emits the link-register write for JAL. It sits in the EX stage of the branch pipe, between ID/EX and the program counter, with link results feeding EX/WB.

---
 rtl/vliw_pkg.sv | 19 +
 rtl/branch_cond.sv | 45 ++++
 rtl/branch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW core: branch opcodes and bundle geometry.
package vliw_pkg;

    typedef enum logic [2:0] {
        BEQ = 3'd0,
        BNE = 3'd1,
        BLT = 3'd2,
        BGE = 3'd3,
        J   = 3'd4,
        JAL = 3'd5,
        JR  = 3'd6
    } br_op_t;

    localparam logic [31:0] BUNDLE_BYTES = 32'd16;
    localparam int unsigned BUNDLE_SHIFT = 4;
    localparam logic [31:0] RESET_PC     = 32'h0040_0020;
    localparam logic [4:0]  LINK_REG     = 5'd31;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch resolution: condition, redirect target and JR alignment check.
module branch_cond
    import vliw_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] pc,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    output logic        taken,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] imm_sext;
    logic [31:0] rel_target;
    logic [31:0] jr_target;

    // Offset is in bundles, so scale the sign-extended immediate to bytes.
    assign imm_sext   = {{16{imm[15]}}, imm};
    assign rel_target = pc + BUNDLE_BYTES + (imm_sext << BUNDLE_SHIFT);
    assign jr_target  = rs_val & 32'hFFFF_FFF0;

    // Decode the op into taken/target; unknown encodings resolve not-taken.
    always_comb begin
        taken      = 1'b0;
        target     = rel_target;
        misaligned = 1'b0;
        case (br_op_t'(op))
            BEQ: taken = (rs_val == rt_val);
            BNE: taken = (rs_val != rt_val);
            BLT: taken = ($signed(rs_val) < $signed(rt_val));
            BGE: taken = ($signed(rs_val) >= $signed(rt_val));
            J:   taken = 1'b1;
            JAL: taken = 1'b1;
            JR: begin
                taken      = 1'b1;
                target     = jr_target;
                misaligned = (rs_val[3:0] != 4'd0);
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch-slot EX unit: accept gating, post-redirect shadow, link write and taken counter.
module branch_unit
    import vliw_pkg::*;
#(
    parameter int unsigned SHADOW_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic [2:0]  br_op,
    input  logic [31:0] bundle_pc,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    output logic        branch_taken,
    output logic [31:0] new_pc,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        misalign,
    output logic [31:0] taken_count
);

    localparam int unsigned CntW = (SHADOW_CYCLES < 1) ? 1 : $clog2(SHADOW_CYCLES + 1);

    logic            cond_taken;
    logic [31:0]     cond_target;
    logic            cond_misaligned;
    logic            accept;
    logic            take;
    logic            is_jal;

    logic [CntW-1:0] shadow_cnt_q, shadow_cnt_d;
    logic            link_we_q, link_we_d;
    logic [31:0]     link_data_q, link_data_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     taken_count_q, taken_count_d;

    branch_cond u_branch_cond (
        .op         (br_op),
        .pc         (bundle_pc),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .imm        (imm),
        .taken      (cond_taken),
        .target     (cond_target),
        .misaligned (cond_misaligned)
    );

    // Wrong-path ops during the shadow (or under reset) are dropped entirely.
    always_comb begin
        accept       = br_valid && (shadow_cnt_q == '0) && !rst;
        take         = accept && cond_taken;
        is_jal       = (br_op == JAL);
        branch_taken = take;
        new_pc       = take ? cond_target : 32'd0;
    end

    // Next state for the shadow counter and the one-cycle result registers.
    always_comb begin
        shadow_cnt_d  = shadow_cnt_q;
        link_we_d     = 1'b0;
        link_data_d   = 32'd0;
        misalign_d    = 1'b0;
        taken_count_d = taken_count_q;
        if (take) begin
            shadow_cnt_d  = CntW'(SHADOW_CYCLES);
            taken_count_d = taken_count_q + 32'd1;
        end else if (shadow_cnt_q != '0) begin
            shadow_cnt_d = shadow_cnt_q - CntW'(1);
        end
        if (take && is_jal) begin
            link_we_d   = 1'b1;
            link_data_d = bundle_pc + BUNDLE_BYTES;
        end
        if (take && cond_misaligned) begin
            misalign_d = 1'b1;
        end
    end

    // State registers; asynchronous reset also clears any shadow in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_cnt_q  <= '0;
            link_we_q     <= 1'b0;
            link_data_q   <= 32'd0;
            misalign_q    <= 1'b0;
            taken_count_q <= 32'd0;
        end else begin
            shadow_cnt_q  <= shadow_cnt_d;
            link_we_q     <= link_we_d;
            link_data_q   <= link_data_d;
            misalign_q    <= misalign_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign link_we     = link_we_q;
    assign link_data   = link_data_q;
    assign misalign    = misalign_q;
    assign taken_count = taken_count_q;

endmodule
